// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bundle for serial_subtractor
// master drives input_start/input_a/input_b; slave drives output_busy/output_done/output_diff/output_borrow
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             input_start;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             output_busy;
    logic             output_done;
    logic [WIDTH-1:0] output_diff;
    logic             output_borrow;
    modport master (
        output input_start, input_a, input_b,
        input  output_busy, output_done, output_diff, output_borrow
    );
    modport slave (
        input  input_start, input_a, input_b,
        output output_busy, output_done, output_diff, output_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor cell and a registered borrow
// input_clk: rising-edge clock; input_reset: synchronous active-high reset
// bus (slave): input_start/input_a/input_b in; output_busy/output_done/output_diff/output_borrow out
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic                input_clk,
    input logic                input_reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_next, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, br_next, d, borrow_q, last;
    assign d        = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // new bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
    assign res_next = (WIDTH'(d) << (WIDTH - 1)) | (res >> 1);
    assign last     = cnt == LAST;
    always_ff @(posedge input_clk)
        state <= input_reset ? IDLE : state_next;
    always_comb begin
        state_next = state == IDLE ? (bus.input_start ? RUN : IDLE)
                   : state == RUN  ? (last ? DONE : RUN)
                   : IDLE;
    end
    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (state == IDLE && bus.input_start) begin
            a_sh <= bus.input_a;
            b_sh <= bus.input_b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_next;
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            // the final bit is still in flight, so publish the next-state values
            if (last) begin
                diff_q   <= res_next;
                borrow_q <= br_next;
            end
        end
    end
    assign bus.output_busy   = state != IDLE;
    assign bus.output_done   = state == DONE;
    assign bus.output_diff   = diff_q;
    assign bus.output_borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    serial_subtractor_if #(.WIDTH(8)) bus8();
    serial_subtractor_if #(.WIDTH(1)) bus1();
    serial_subtractor #(.WIDTH(8)) dut8 (.input_clk(clk), .input_reset(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.input_clk(clk), .input_reset(rst), .bus(bus1));

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.input_start = 1'b1;
        bus8.input_a = a;
        bus8.input_b = b;
        @(posedge clk);
        #1 bus8.input_start = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus8.output_done && n < 40);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus8.input_start = 1'b1;
        bus8.input_a = 8'hA5;
        bus8.input_b = 8'h11;
        bus1.input_start = 1'b1;
        bus1.input_a = 1'b1;
        bus1.input_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus8.output_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus8.output_busy); end
            total++; if (bus8.output_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus8.output_done); end
            total++; if (bus8.output_diff !== 8'h00) begin bad++; $display("FAIL reset_diff: got %h want 00", bus8.output_diff); end
            total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow: got %b want 0", bus8.output_borrow); end
            total++; if (bus1.output_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_w1: got %b want 0", bus1.output_busy); end
        end
        bus8.input_start = 1'b0;
        bus1.input_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        start8(8'h5A, 8'h23);
        wait8(n);
        total++; if (n != 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'h37) begin bad++; $display("FAIL basic_diff: got %h want 37", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL basic_borrow: got %b want 0", bus8.output_borrow); end
        total++; if (bus8.output_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_in_done: got %b want 1", bus8.output_busy); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; if (bus8.output_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: cycle %0d got %b want 0", i, bus8.output_done); end
            total++; if (bus8.output_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: cycle %0d got %b want 0", i, bus8.output_busy); end
            total++; if (bus8.output_diff !== 8'h37 || bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL basic_hold: cycle %0d got %h/%b want 37/0", i, bus8.output_diff, bus8.output_borrow); end
        end
    endtask

    task automatic test_borrow;
        int n;
        start8(8'h00, 8'h01);
        wait8(n);
        total++; if (n != 9) begin bad++; $display("FAIL borrow_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'hFF) begin bad++; $display("FAIL borrow_diff: got %h want ff", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b1) begin bad++; $display("FAIL borrow_flag: got %b want 1", bus8.output_borrow); end
        start8(8'hFF, 8'hFF);
        wait8(n);
        total++; if (n != 9) begin bad++; $display("FAIL equal_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'h00) begin bad++; $display("FAIL equal_diff: got %h want 00", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL equal_borrow: got %b want 0", bus8.output_borrow); end
    endtask

    task automatic test_back_to_back;
        int n;
        start8(8'h80, 8'h7F);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                bus8.input_start = 1'b1;
                bus8.input_a = 8'h10;
                bus8.input_b = 8'h01;
            end
            if (n == 4) bus8.input_start = 1'b0;
        end while (!bus8.output_done && n < 40);
        total++; if (n != 9) begin bad++; $display("FAIL ignore_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'h01) begin bad++; $display("FAIL ignore_diff: got %h want 01", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL ignore_borrow: got %b want 0", bus8.output_borrow); end
        @(negedge clk);
        total++; if (bus8.output_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", bus8.output_busy); end
        bus8.input_start = 1'b1;
        bus8.input_a = 8'h10;
        bus8.input_b = 8'h01;
        @(posedge clk);
        #1 bus8.input_start = 1'b0;
        wait8(n);
        total++; if (n != 9) begin bad++; $display("FAIL b2b_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'h0F) begin bad++; $display("FAIL b2b_diff: got %h want 0f", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL b2b_borrow: got %b want 0", bus8.output_borrow); end
    endtask

    task automatic test_reset_abort;
        int n;
        int dones;
        start8(8'h5A, 8'h23);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus8.output_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus8.output_busy); end
        total++; if (bus8.output_done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", bus8.output_done); end
        total++; if (bus8.output_diff !== 8'h00) begin bad++; $display("FAIL abort_diff: got %h want 00", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b0) begin bad++; $display("FAIL abort_borrow: got %b want 0", bus8.output_borrow); end
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.output_done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        start8(8'h03, 8'h05);
        wait8(n);
        total++; if (n != 9) begin bad++; $display("FAIL after_abort_latency: got %0d want 9", n); end
        total++; if (bus8.output_diff !== 8'hFE) begin bad++; $display("FAIL after_abort_diff: got %h want fe", bus8.output_diff); end
        total++; if (bus8.output_borrow !== 1'b1) begin bad++; $display("FAIL after_abort_borrow: got %b want 1", bus8.output_borrow); end
    endtask

    task automatic test_width1;
        logic [3:0] av, bv, dv, brv;
        int n;
        av  = 4'b1100;
        bv  = 4'b1010;
        dv  = 4'b0110;
        brv = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.input_start = 1'b1;
            bus1.input_a = av[i];
            bus1.input_b = bv[i];
            @(posedge clk);
            #1 bus1.input_start = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus1.output_done && n < 10);
            total++; if (n != 2) begin bad++; $display("FAIL w1_latency[%0d]: got %0d want 2", i, n); end
            total++; if (bus1.output_diff !== dv[i]) begin bad++; $display("FAIL w1_diff[%0d]: got %b want %b", i, bus1.output_diff, dv[i]); end
            total++; if (bus1.output_borrow !== brv[i]) begin bad++; $display("FAIL w1_borrow[%0d]: got %b want %b", i, bus1.output_borrow, brv[i]); end
        end
    endtask

    initial begin
        bus8.input_start = 1'b0;
        bus8.input_a = '0;
        bus8.input_b = '0;
        bus1.input_start = 1'b0;
        bus1.input_a = '0;
        bus1.input_b = '0;
        test_reset;
        test_basic;
        test_borrow;
        test_back_to_back;
        test_reset_abort;
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
